// File: rtl/reg_file_latched.sv
// MIPS register file: 2 read ports, 1 write port, r0 hardwired to zero, optional
// write-to-read bypass, registered A/B operand latches and a sequenced bulk-clear engine.
module reg_file_latched #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned BYPASS = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Reg_Write_i,
  input  logic [ADDR_W-1:0] Write_Register_i,
  input  logic [DATA_W-1:0] Write_Data_i,
  input  logic [ADDR_W-1:0] Read_Register_1_i,
  input  logic [ADDR_W-1:0] Read_Register_2_i,
  input  logic              Latch_En_i,
  input  logic              Clear_i,
  output logic [DATA_W-1:0] Read_Data_1_o,
  output logic [DATA_W-1:0] Read_Data_2_o,
  output logic [DATA_W-1:0] A_o,
  output logic [DATA_W-1:0] B_o,
  output logic              Busy_o
);

  localparam int unsigned       DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ZERO_IDX = '0;
  localparam logic [ADDR_W-1:0] ONE_IDX  = ADDR_W'(1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_cnt;
  logic                r_busy;
  logic [DATA_W-1:0]   r_regs [DEPTH];
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic                w_wr_en;
  logic [DATA_W-1:0]   w_rd1;
  logic [DATA_W-1:0]   w_rd2;

  assign w_wr_en = Reg_Write_i && !r_busy && (Write_Register_i != ZERO_IDX);

  // Read port 1: zero for r0 or while clearing, then bypass, then storage
  always_comb begin
    w_rd1 = r_regs[Read_Register_1_i];
    if ((Read_Register_1_i == ZERO_IDX) || r_busy) begin
      w_rd1 = '0;
    end else if ((BYPASS != 0) && Reg_Write_i && (Read_Register_1_i == Write_Register_i)) begin
      w_rd1 = Write_Data_i;
    end
  end

  always_comb begin
    w_rd2 = r_regs[Read_Register_2_i];
    if ((Read_Register_2_i == ZERO_IDX) || r_busy) begin
      w_rd2 = '0;
    end else if ((BYPASS != 0) && Reg_Write_i && (Read_Register_2_i == Write_Register_i)) begin
      w_rd2 = Write_Data_i;
    end
  end

  // Storage: the clear engine owns the array while busy, so writes are dropped
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else if (r_busy) begin
      r_regs[r_cnt] <= '0;
    end else if (w_wr_en) begin
      r_regs[Write_Register_i] <= Write_Data_i;
    end
  end

  // Clear sequencer; r0 is never written so the sweep starts at 1
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= ZERO_IDX;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Clear_i) begin
            r_state <= S_CLEAR;
            r_cnt   <= ONE_IDX;
            r_busy  <= 1'b1;
          end
        end
        S_CLEAR: begin
          if (r_cnt == LAST_IDX) begin
            r_state <= S_IDLE;
            r_cnt   <= ZERO_IDX;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + ONE_IDX;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= ZERO_IDX;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a <= '0;
      r_b <= '0;
    end else if (Latch_En_i) begin
      r_a <= w_rd1;
      r_b <= w_rd2;
    end
  end

  assign Read_Data_1_o = w_rd1;
  assign Read_Data_2_o = w_rd2;
  assign A_o           = r_a;
  assign B_o           = r_b;
  assign Busy_o        = r_busy;

endmodule

// File: tb/tb_reg_file_latched.sv
// Directed bench for reg_file_latched: default 32x32 bypass instance and a
// 16-bit, 8-entry, no-bypass instance sharing clock and reset.
module tb_reg_file_latched;

  logic clk;
  logic rst_n;

  // 32-bit, 32-entry, BYPASS=1 instance
  logic        we, latch, clr;
  logic [4:0]  wa, ra1, ra2;
  logic [31:0] wd;
  logic [31:0] rd1, rd2, a_o, b_o;
  logic        busy;

  // 16-bit, 8-entry, BYPASS=0 instance
  logic        s_we, s_latch, s_clr;
  logic [2:0]  s_wa, s_ra1, s_ra2;
  logic [15:0] s_wd;
  logic [15:0] s_rd1, s_rd2, s_a, s_b;
  logic        s_busy;

  int errors = 0;
  int checks = 0;

  reg_file_latched u_dut (
    .clk(clk), .reset(rst_n), .Reg_Write_i(we), .Write_Register_i(wa), .Write_Data_i(wd),
    .Read_Register_1_i(ra1), .Read_Register_2_i(ra2), .Latch_En_i(latch), .Clear_i(clr),
    .Read_Data_1_o(rd1), .Read_Data_2_o(rd2), .A_o(a_o), .B_o(b_o), .Busy_o(busy)
  );

  reg_file_latched #(.DATA_W(16), .ADDR_W(3), .BYPASS(0)) u_small (
    .clk(clk), .reset(rst_n), .Reg_Write_i(s_we), .Write_Register_i(s_wa), .Write_Data_i(s_wd),
    .Read_Register_1_i(s_ra1), .Read_Register_2_i(s_ra2), .Latch_En_i(s_latch), .Clear_i(s_clr),
    .Read_Data_1_o(s_rd1), .Read_Data_2_o(s_rd2), .A_o(s_a), .B_o(s_b), .Busy_o(s_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 ns after the rising edge; outputs are sampled there too
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; wa = a; wd = d;
    tick();
    we = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i);
      ra2 = 5'(31 - i);
      #1;
      checks++;
      if (rd1 !== 32'h0 || rd2 !== 32'h0) begin
        errors++;
        $display("FAIL reset_read[%0d]: rd1=%h rd2=%h expected 0", i, rd1, rd2);
      end
    end
    checks++;
    if (a_o !== 32'h0 || b_o !== 32'h0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: A=%h B=%h busy=%b expected 0/0/0", a_o, b_o, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    wr(5'd5, 32'hDEADBEEF);
    ra1 = 5'd5; ra2 = 5'd5;
    #1;
    checks++;
    if (rd1 !== 32'hDEADBEEF || rd2 !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL write_r5: rd1=%h rd2=%h expected deadbeef", rd1, rd2);
    end
    // r0 bypass must also stay suppressed while the write is presented
    we = 1'b1; wa = 5'd0; wd = 32'h1234; ra1 = 5'd0;
    #1;
    checks++;
    if (rd1 !== 32'h0) begin
      errors++;
      $display("FAIL r0_bypass: rd1=%h expected 0", rd1);
    end
    tick();
    we = 1'b0;
    #1;
    checks++;
    if (rd1 !== 32'h0) begin
      errors++;
      $display("FAIL r0_write: rd1=%h expected 0", rd1);
    end
  endtask

  task automatic test_bypass_latch();
    we = 1'b1; wa = 5'd7; wd = 32'hA5A5A5A5; ra1 = 5'd7; ra2 = 5'd5; latch = 1'b1;
    #1;
    checks++;
    if (rd1 !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL bypass_rd1: got %h expected a5a5a5a5", rd1);
    end
    tick();
    we = 1'b0; latch = 1'b0;
    checks++;
    if (a_o !== 32'hA5A5A5A5 || b_o !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL latch_ab: A=%h B=%h expected a5a5a5a5/deadbeef", a_o, b_o);
    end
    ra1 = 5'd5;
    tick();
    checks++;
    if (a_o !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL latch_hold: A=%h expected a5a5a5a5", a_o);
    end
  endtask

  task automatic test_clear();
    int n;
    int bad;
    for (int i = 1; i < 32; i++) wr(5'(i), 32'(i));
    ra1 = 5'd17; ra2 = 5'd31;
    #1;
    checks++;
    if (rd1 !== 32'd17 || rd2 !== 32'd31) begin
      errors++;
      $display("FAIL fill: rd1=%h rd2=%h expected 11/1f", rd1, rd2);
    end
    // write on the clear-start edge commits and then gets swept
    clr = 1'b1; we = 1'b1; wa = 5'd4; wd = 32'h44;
    tick();
    clr = 1'b0; we = 1'b0;
    ra1 = 5'd20;
    #1;
    checks++;
    if (busy !== 1'b1 || rd1 !== 32'h0) begin
      errors++;
      $display("FAIL clear_start: busy=%b rd1=%h expected 1/0", busy, rd1);
    end
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      we    = (n == 5);
      wa    = 5'd3;
      wd    = 32'hFF;
      latch = (n == 8);
      tick();
    end
    we = 1'b0; latch = 1'b0;
    checks++;
    if (n != 31) begin
      errors++;
      $display("FAIL clear_len: busy cycles=%0d expected 31", n);
    end
    checks++;
    if (a_o !== 32'h0 || b_o !== 32'h0) begin
      errors++;
      $display("FAIL latch_busy: A=%h B=%h expected 0", a_o, b_o);
    end
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i); ra2 = 5'(i);
      #1;
      if (rd1 !== 32'h0 || rd2 !== 32'h0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL clear_sweep: nonzero regs=%0d expected 0", bad);
    end
  endtask

  task automatic test_reset_mid_clear();
    wr(5'd9, 32'h99);
    wr(5'd20, 32'd20);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (9) tick();
    rst_n = 1'b0;
    ra1 = 5'd20; ra2 = 5'd9;
    #1;
    checks++;
    if (busy !== 1'b0 || rd1 !== 32'h0 || rd2 !== 32'h0) begin
      errors++;
      $display("FAIL reset_abort: busy=%b rd1=%h rd2=%h expected 0/0/0", busy, rd1, rd2);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    wr(5'd9, 32'h55);
    ra1 = 5'd9;
    #1;
    checks++;
    if (rd1 !== 32'h55 || busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_write: rd1=%h busy=%b expected 55/0", rd1, busy);
    end
  endtask

  task automatic test_small_no_bypass();
    int n;
    s_we = 1'b1; s_wa = 3'd2; s_wd = 16'hBEEF; s_ra1 = 3'd2; s_ra2 = 3'd7; s_latch = 1'b1;
    #1;
    checks++;
    if (s_rd1 !== 16'h0000) begin
      errors++;
      $display("FAIL nobypass_old: rd1=%h expected 0000", s_rd1);
    end
    tick();
    s_we = 1'b0; s_latch = 1'b0;
    #1;
    checks++;
    if (s_rd1 !== 16'hBEEF || s_a !== 16'h0000) begin
      errors++;
      $display("FAIL nobypass_new: rd1=%h A=%h expected beef/0000", s_rd1, s_a);
    end
    s_clr = 1'b1;
    tick();
    s_clr = 1'b0;
    n = 0;
    while (s_busy === 1'b1 && n < 20) begin
      n++;
      tick();
    end
    checks++;
    if (n != 7) begin
      errors++;
      $display("FAIL small_clear_len: busy cycles=%0d expected 7", n);
    end
    #1;
    checks++;
    if (s_rd1 !== 16'h0000) begin
      errors++;
      $display("FAIL small_cleared: rd1=%h expected 0000", s_rd1);
    end
  endtask

  initial begin
    we = 0; latch = 0; clr = 0; wa = '0; ra1 = '0; ra2 = '0; wd = '0;
    s_we = 0; s_latch = 0; s_clr = 0; s_wa = '0; s_ra1 = '0; s_ra2 = '0; s_wd = '0;
    rst_n = 1'b1;
    test_reset();
    test_write_read();
    test_bypass_latch();
    test_clear();
    test_reset_mid_clear();
    test_small_no_bypass();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
